uart_echo_fifo: RTL and testbench
=================================

// Module: uart_echo_fifo
// PURPOSE
//   Byte FIFO plus transmit sequencer between uart_rx (strobe-qualified bytes) and uart_tx.
//   Absorbs bursts arriving faster than uart_tx drains them; no echoed byte is lost while space remains.
//   Optionally expands CR (0x0D) into CR LF on the transmit side.
//   Sits in the serial loopback path of the top level, clocked by the 48 MHz mclk.
// PARAMETERS
//   DEPTH_LOG2     4    FIFO depth = 2**DEPTH_LOG2 bytes
//   CRLF_EXPAND    1    1: a CR byte popped from the FIFO is followed by an inserted LF (0x0A)
//   START_TIMEOUT  64   mclk cycles to wait for tx_busy to rise after tx_strobe (range 2..255)
// PORTS
//   mclk            in   1             system clock; all logic on its rising edge
//   reset           in   1             synchronous, active-low reset
//   in_data         in   8             byte from uart_rx
//   in_strobe       in   1             1-cycle pulse; in_data valid this cycle
//   tx_data         out  8             byte to uart_tx; held stable until the next tx_strobe
//   tx_strobe       out  1             1-cycle pulse requesting transmission of tx_data
//   tx_busy         in   1             high while uart_tx is shifting a byte
//   count           out  DEPTH_LOG2+1  bytes currently stored (0..2**DEPTH_LOG2)
//   overflow        out  1             sticky; set when a byte is dropped on full
//   overflow_clear  in   1             1-cycle pulse clearing overflow
// BEHAVIOUR
//   Reset (reset==0 at a clock edge):
//     - count=0, pointers=0, tx_data=0, tx_strobe=0, overflow=0, FSM in IDLE
//     - Reset mid-operation discards all stored bytes and any pending LF insertion.
//   Push: in_strobe && !full writes in_data at wr_ptr, wr_ptr++ (wraps mod depth).
//     - in_strobe && full: byte dropped, overflow<=1.
//     - Exception: a push coincident with a pop while full is accepted.
//   overflow_clear and a drop in the same cycle: overflow stays 1 (set wins).
//   count = pushes - pops. It updates the cycle after the event; a simultaneous push and pop leave it unchanged.
//   FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE, ISSUE_LF.
//     - IDLE:       if count!=0, pop (rd_ptr++) -> ISSUE.
//     - ISSUE:      tx_data<=popped byte, tx_strobe=1 for exactly this cycle -> WAIT_START.
//     - WAIT_START: tx_busy==1 -> WAIT_DONE.
//                   START_TIMEOUT cycles without busy -> WAIT_DONE (byte treated as sent).
//     - WAIT_DONE:  tx_busy==0 -> ISSUE_LF if (CRLF_EXPAND && last byte==8'h0D && LF not yet sent), else IDLE.
//     - ISSUE_LF:   tx_data<=8'h0A, tx_strobe=1 for one cycle -> WAIT_START. The LF is not taken from the FIFO.
//   Latency: push at cycle N into an empty FIFO with the FSM in IDLE gives tx_strobe at N+2.
//   tx_strobe is never asserted in consecutive cycles and never while tx_busy==1.
//   Storage: registered-read RAM (infers iCE40 BRAM for DEPTH_LOG2>=8). The read address is presented in the IDLE pop cycle.
//   An LF received from uart_rx is passed through unmodified. Only CR triggers insertion.
// STRUCTURE
//   Shared include (alongside util.v):
//     - ASCII_CR=8'h0D, ASCII_LF=8'h0A
//     - FSM state localparams (3-bit encoding)
//   Sub-module fifo_sync #(WIDTH,DEPTH_LOG2):
//     - pointers, count, full/empty, overflow flag, registered read port
//   Top of this block: the transmit FSM and the START_TIMEOUT counter (8 bits).
// TESTING
//   1. Single byte 8'h41, tx_busy model 10 cycles -> tx_strobe at N+2, tx_data=8'h41, count returns to 0.
//   2. Burst of 16 back-to-back strobes (DEPTH_LOG2=4), slow tx -> all 16 sent in order, overflow=0.
//        17th strobe before any pop -> dropped, overflow=1.
//        overflow_clear -> overflow=0.
//   3. Byte 8'h0D with CRLF_EXPAND=1 -> two strobes, 8'h0D then 8'h0A, count decrements once.
//        With CRLF_EXPAND=0 -> one strobe only.
//   4. tx_busy tied 0 -> next strobe 2+START_TIMEOUT cycles after the previous one; no hang.
//   5. Push and pop in the same cycle at full -> count stays 16, byte accepted, overflow=0.
//   6. reset low during WAIT_DONE with 5 bytes queued -> count=0, tx_strobe=0, IDLE.
//        No further strobes until a new push.

Source files
------------

// File: rtl/uart_echo_fifo_pkg.sv
// Shared constants and state encoding for the UART echo FIFO.
// ASCII codes, transmit FSM states and small byte helpers.
package uart_echo_fifo_pkg;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_ISSUE      = 3'd1,
      ST_WAIT_START = 3'd2,
      ST_WAIT_DONE  = 3'd3,
      ST_ISSUE_LF   = 3'd4
   } tx_state_e;

   function automatic logic is_cr(input logic [7:0] b);
      return b == ASCII_CR;
   endfunction

endpackage

// File: rtl/uart_echo_fifo_fifo_sync.sv
// Synchronous byte FIFO with registered read port and sticky overflow.
// A push while full is accepted only when a pop happens in the same cycle.
module fifo_sync #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  mclk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rd_data,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  empty,
   output logic                  overflow,
   input  logic                  overflow_clear
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic [WIDTH-1:0]      rd_data_q;
   logic [WIDTH-1:0]      mem [DEPTH];
   logic                  full;
   logic                  push;
   logic                  pop;

   assign full  = count_q == FULL_CNT;
   assign empty = count_q == '0;
   assign pop   = rd_en && !empty;
   assign push  = wr_en && (!full || pop);

   assign rd_data  = rd_data_q;
   assign count    = count_q;
   assign overflow = ovf_q;

   // Next pointers, occupancy and sticky overflow (a drop beats a clear).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (overflow_clear) ovf_d = 1'b0;
      if (wr_en && !push) ovf_d = 1'b1;
   end

   // Control state registers.
   always_ff @(posedge mclk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage array; no reset so it maps onto block RAM.
   always_ff @(posedge mclk) begin
      if (push) mem[wr_ptr_q] <= wr_data;
   end

   // Registered read; holds the last popped byte until the next pop.
   always_ff @(posedge mclk) begin
      if (!reset) begin
         rd_data_q <= '0;
      end else if (pop) begin
         rd_data_q <= mem[rd_ptr_q];
      end
   end

endmodule

// File: rtl/uart_echo_fifo.sv
// Echo FIFO and transmit sequencer between uart_rx and uart_tx.
// Optionally follows every transmitted CR with an inserted LF.
module uart_echo_fifo
   import uart_echo_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2    = 4,
   parameter int CRLF_EXPAND   = 1,
   parameter int START_TIMEOUT = 64
) (
   input  logic                mclk,
   input  logic                reset,
   input  logic [7:0]          in_data,
   input  logic                in_strobe,
   output logic [7:0]          tx_data,
   output logic                tx_strobe,
   input  logic                tx_busy,
   output logic [DEPTH_LOG2:0] count,
   output logic                overflow,
   input  logic                overflow_clear
);

   // Strobe cycle counts as the first cycle of the start window.
   localparam logic [7:0] TMO_LAST = 8'(START_TIMEOUT - 1);

   tx_state_e  state_q, state_d;
   logic       strobe_q, strobe_d;
   logic       lf_sel_q, lf_sel_d;
   logic [7:0] tmr_q, tmr_d;
   logic       pop;
   logic       empty;
   logic [7:0] rd_data;
   logic       need_lf;

   fifo_sync #(
      .WIDTH      (8),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .mclk           (mclk),
      .reset          (reset),
      .wr_en          (in_strobe),
      .wr_data        (in_data),
      .rd_en          (pop),
      .rd_data        (rd_data),
      .count          (count),
      .empty          (empty),
      .overflow       (overflow),
      .overflow_clear (overflow_clear)
   );

   // The RAM output register doubles as the tx_data hold register.
   assign tx_data   = lf_sel_q ? ASCII_LF : rd_data;
   assign tx_strobe = strobe_q;
   assign need_lf   = (CRLF_EXPAND != 0) && !lf_sel_q
                      && is_cr(rd_data);

   // Transmit sequencing: pop, strobe, wait for start, wait for done.
   always_comb begin
      state_d  = state_q;
      strobe_d = 1'b0;
      lf_sel_d = lf_sel_q;
      tmr_d    = tmr_q;
      pop      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               strobe_d = 1'b1;
               lf_sel_d = 1'b0;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE, ST_ISSUE_LF: begin
            tmr_d   = 8'd1;
            state_d = ST_WAIT_START;
         end
         ST_WAIT_START: begin
            if (tx_busy || tmr_q == TMO_LAST) begin
               state_d = ST_WAIT_DONE;
            end else begin
               tmr_d = tmr_q + 8'd1;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               if (need_lf) begin
                  strobe_d = 1'b1;
                  lf_sel_d = 1'b1;
                  state_d  = ST_ISSUE_LF;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer registers; reset drops any pending LF insertion.
   always_ff @(posedge mclk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         strobe_q <= 1'b0;
         lf_sel_q <= 1'b0;
         tmr_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         strobe_q <= strobe_d;
         lf_sel_q <= lf_sel_d;
         tmr_q    <= tmr_d;
      end
   end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Randomized bench for uart_echo_fifo with a byte-stream reference model.
// A uart_tx stand-in drives tx_busy; transmitted bytes are scoreboarded.
module tb_uart_echo_fifo;

   localparam int T1 = 20;
   localparam int T2 = 8;

   logic       mclk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_strobe = 1'b0;
   logic       overflow_clear = 1'b0;
   logic [7:0] tx_data;
   logic       tx_strobe;
   logic       tx_busy = 1'b0;
   logic [4:0] count;
   logic       overflow;

   logic       en2 = 1'b0;
   logic       in_strobe2;
   logic       tx_busy2;
   logic [7:0] tx_data2;
   logic       tx_strobe2;
   logic [4:0] count2;
   logic       overflow2;

   assign in_strobe2 = in_strobe & en2;
   assign tx_busy2   = 1'b0;

   uart_echo_fifo #(
      .DEPTH_LOG2(4), .CRLF_EXPAND(1), .START_TIMEOUT(T1)
   ) dut (
      .mclk(mclk), .reset(reset), .in_data(in_data),
      .in_strobe(in_strobe), .tx_data(tx_data),
      .tx_strobe(tx_strobe), .tx_busy(tx_busy),
      .count(count), .overflow(overflow),
      .overflow_clear(overflow_clear)
   );

   uart_echo_fifo #(
      .DEPTH_LOG2(4), .CRLF_EXPAND(0), .START_TIMEOUT(T2)
   ) dut2 (
      .mclk(mclk), .reset(reset), .in_data(in_data),
      .in_strobe(in_strobe2), .tx_data(tx_data2),
      .tx_strobe(tx_strobe2), .tx_busy(tx_busy2),
      .count(count2), .overflow(overflow2),
      .overflow_clear(overflow_clear)
   );

   always #10 mclk = ~mclk;

   typedef struct {
      logic [7:0] d;
      int         t;
      logic       busy;
      logic       consec;
   } obs_t;

   obs_t       obs_q[$];
   logic [7:0] exp_q[$];
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         mode = 1;
   int         busy_len = 3;
   int         busy_cnt = 0;
   logic       held = 1'b0;
   logic       prev_strobe = 1'b0;
   int         s2_cnt = 0;
   logic [7:0] s2_last = 8'h00;

   always @(posedge mclk) cyc <= cyc + 1;

   // uart_tx stand-in: busy rises the cycle after a strobe.
   always @(posedge mclk) begin
      #2;
      if (mode == 0) begin
         tx_busy = 1'b0; busy_cnt = 0; held = 1'b0;
      end else if (tx_strobe === 1'b1) begin
         tx_busy = 1'b0; busy_cnt = busy_len; held = (mode == 2);
      end else if (held && mode == 2) begin
         tx_busy = 1'b1; busy_cnt = 0;
      end else begin
         held = 1'b0;
         if (busy_cnt > 0) begin
            tx_busy = 1'b1; busy_cnt = busy_cnt - 1;
         end else begin
            tx_busy = 1'b0;
         end
      end
   end

   // Record every transmit request of the main instance.
   always @(negedge mclk) begin
      if (tx_strobe === 1'b1) begin
         obs_q.push_back('{tx_data, cyc, tx_busy, prev_strobe});
      end
      prev_strobe = tx_strobe;
   end

   // Tally transmit requests of the no-expansion instance.
   always @(negedge mclk) begin
      if (tx_strobe2 === 1'b1) begin
         s2_cnt = s2_cnt + 1;
         s2_last = tx_data2;
      end
   end

   // Reference: every accepted byte is sent once, CR gains a trailing LF.
   function automatic void model_push(input logic [7:0] b);
      exp_q.push_back(b);
      if (b == 8'h0D) exp_q.push_back(8'h0A);
   endfunction

   function automatic logic [7:0] rnd_nocr();
      logic [7:0] b;
      do b = 8'($urandom); while (b == 8'h0D);
      return b;
   endfunction

   task automatic wait_obs(input int n, input int budget,
                           output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (obs_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         @(negedge mclk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge mclk);
      n_cmp++;
      if (count !== 5'd0) begin
         n_bad++; $display("FAIL reset_count got %0d want 0", count);
      end
      n_cmp++;
      if (tx_strobe !== 1'b0) begin
         n_bad++; $display("FAIL reset_strobe got %b want 0", tx_strobe);
      end
      n_cmp++;
      if (tx_data !== 8'h00) begin
         n_bad++; $display("FAIL reset_data got %h want 00", tx_data);
      end
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_bad++; $display("FAIL reset_ovf got %b want 0", overflow);
      end
      reset = 1'b1;
      @(negedge mclk);
   endtask

   task automatic test_single_byte();
      int a;
      bit ok;
      obs_t o;
      mode = 1; busy_len = 10;
      a = cyc;
      in_data = 8'h41; in_strobe = 1'b1;
      @(negedge mclk);
      in_strobe = 1'b0;
      n_cmp++;
      if (count !== 5'd1) begin
         n_bad++; $display("FAIL single_cnt1 got %0d want 1", count);
      end
      wait_obs(1, 200, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++; $display("FAIL single_timeout got none want 1 strobe");
      end else begin
         o = obs_q.pop_front();
         n_cmp++;
         if (o.t !== a + 2) begin
            n_bad++; $display("FAIL single_lat got %0d want %0d", o.t, a + 2);
         end
         n_cmp++;
         if (o.d !== 8'h41) begin
            n_bad++; $display("FAIL single_data got %h want 41", o.d);
         end
      end
      repeat (20) @(negedge mclk);
      n_cmp++;
      if (count !== 5'd0) begin
         n_bad++; $display("FAIL single_cnt0 got %0d want 0", count);
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      bit ok;
      obs_t o;
      logic [7:0] b;
      mode = 2; busy_len = 3;
      b = rnd_nocr(); model_push(b);
      in_data = b; in_strobe = 1'b1;
      @(negedge mclk);
      in_strobe = 1'b0;
      repeat (4) @(negedge mclk);
      for (int i = 0; i < 16; i++) begin
         b = 8'($urandom); model_push(b);
         in_data = b; in_strobe = 1'b1;
         @(negedge mclk);
      end
      in_strobe = 1'b0;
      n_cmp++;
      if (count !== 5'd16) begin
         n_bad++; $display("FAIL burst_full got %0d want 16", count);
      end
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_bad++; $display("FAIL burst_ovf got %b want 0", overflow);
      end
      in_data = 8'($urandom); in_strobe = 1'b1;
      @(negedge mclk);
      in_strobe = 1'b0;
      n_cmp++;
      if (overflow !== 1'b1 || count !== 5'd16) begin
         n_bad++;
         $display("FAIL drop ovf/cnt got %b/%0d want 1/16", overflow, count);
      end
      overflow_clear = 1'b1;
      @(negedge mclk);
      overflow_clear = 1'b0;
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_bad++; $display("FAIL ovf_clear got %b want 0", overflow);
      end
      mode = 1;
      repeat (2) @(negedge mclk);
      b = 8'($urandom); model_push(b);
      in_data = b; in_strobe = 1'b1;
      @(negedge mclk);
      in_strobe = 1'b0;
      n_cmp++;
      if (count !== 5'd16 || overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL full_pushpop cnt/ovf got %0d/%b want 16/0",
                  count, overflow);
      end
      wait_obs(exp_q.size(), 3000, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL burst_drain got %0d want %0d strobes",
                  obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         o = obs_q.pop_front(); b = exp_q.pop_front();
         n_cmp++;
         if (o.d !== b || o.busy !== 1'b0 || o.consec !== 1'b0) begin
            n_bad++;
            $display("FAIL burst_byte got %h(b%b c%b) want %h(b0 c0)",
                     o.d, o.busy, o.consec, b);
         end
      end
      repeat (20) @(negedge mclk);
      n_cmp++;
      if (count !== 5'd0 || obs_q.size() != 0) begin
         n_bad++;
         $display("FAIL burst_end cnt/extra got %0d/%0d want 0/0",
                  count, obs_q.size());
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_crlf();
      bit ok;
      obs_t o;
      int base;
      mode = 1; busy_len = 4;
      en2 = 1'b1;
      base = s2_cnt;
      in_data = 8'h0D; in_strobe = 1'b1;
      model_push(8'h0D);
      @(negedge mclk);
      in_strobe = 1'b0;
      n_cmp++;
      if (count !== 5'd1) begin
         n_bad++; $display("FAIL cr_cnt1 got %0d want 1", count);
      end
      wait_obs(2, 300, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++; $display("FAIL cr_timeout got %0d want 2", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         o = obs_q.pop_front();
         n_cmp++;
         if (o.d !== exp_q[0] || o.busy !== 1'b0 || o.consec !== 1'b0) begin
            n_bad++;
            $display("FAIL crlf_byte got %h want %h", o.d, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      repeat (60) @(negedge mclk);
      n_cmp++;
      if (count !== 5'd0 || obs_q.size() != 0) begin
         n_bad++;
         $display("FAIL cr_end cnt/extra got %0d/%0d want 0/0",
                  count, obs_q.size());
      end
      n_cmp++;
      if (s2_cnt - base != 1 || s2_last !== 8'h0D) begin
         n_bad++;
         $display("FAIL noexp strobes/data got %0d/%h want 1/0d",
                  s2_cnt - base, s2_last);
      end
      en2 = 1'b0;
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_timeout();
      bit ok;
      int a;
      obs_t o0, o1;
      logic [7:0] b0, b1;
      mode = 0;
      b0 = rnd_nocr(); b1 = rnd_nocr();
      a = cyc;
      in_data = b0; in_strobe = 1'b1;
      @(negedge mclk);
      in_data = b1;
      @(negedge mclk);
      in_strobe = 1'b0;
      wait_obs(2, 500, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++; $display("FAIL tmo_hang got %0d want 2", obs_q.size());
      end else begin
         o0 = obs_q.pop_front(); o1 = obs_q.pop_front();
         n_cmp++;
         if (o1.t - o0.t != 2 + T1) begin
            n_bad++;
            $display("FAIL tmo_gap got %0d want %0d", o1.t - o0.t, 2 + T1);
         end
         n_cmp++;
         if (o0.t != a + 2 || o0.d !== b0 || o1.d !== b1) begin
            n_bad++;
            $display("FAIL tmo_data got %h,%h@%0d want %h,%h@%0d",
                     o0.d, o1.d, o0.t, b0, b1, a + 2);
         end
      end
      repeat (30) @(negedge mclk);
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      bit ok;
      obs_t o;
      logic [7:0] b;
      int n;
      mode = 1;
      for (int r = 0; r < 8; r++) begin
         busy_len = $urandom_range(1, 6);
         n = $urandom_range(1, 10);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) b = 8'h0D;
            else b = 8'($urandom);
            model_push(b);
            in_data = b; in_strobe = 1'b1;
            @(negedge mclk);
            in_strobe = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge mclk);
         end
         wait_obs(exp_q.size(), 2000, ok);
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL rnd_drain r%0d got %0d want %0d",
                     r, obs_q.size(), exp_q.size());
         end
         while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front(); b = exp_q.pop_front();
            n_cmp++;
            if (o.d !== b || o.busy !== 1'b0 || o.consec !== 1'b0) begin
               n_bad++;
               $display("FAIL rnd_byte got %h(b%b c%b) want %h",
                        o.d, o.busy, o.consec, b);
            end
         end
         repeat (busy_len + 10) @(negedge mclk);
         n_cmp++;
         if (count !== 5'd0 || overflow !== 1'b0 || obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL rnd_end cnt/ovf/extra got %0d/%b/%0d want 0/0/0",
                     count, overflow, obs_q.size());
         end
         obs_q.delete(); exp_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      obs_t o;
      logic [7:0] b;
      logic [7:0] first;
      mode = 2; busy_len = 3;
      // Only the first byte leaves before reset; the rest are discarded.
      first = rnd_nocr();
      in_data = first; in_strobe = 1'b1;
      @(negedge mclk);
      for (int i = 0; i < 5; i++) begin
         in_data = rnd_nocr();
         @(negedge mclk);
      end
      in_strobe = 1'b0;
      repeat (4) @(negedge mclk);
      n_cmp++;
      if (count !== 5'd5) begin
         n_bad++; $display("FAIL rst_pre_cnt got %0d want 5", count);
      end
      reset = 1'b0;
      @(negedge mclk);
      reset = 1'b1;
      mode = 1;
      n_cmp++;
      if (count !== 5'd0 || tx_strobe !== 1'b0 || tx_data !== 8'h00) begin
         n_bad++;
         $display("FAIL rst_mid cnt/stb/data got %0d/%b/%h want 0/0/00",
                  count, tx_strobe, tx_data);
      end
      repeat (40) @(negedge mclk);
      n_cmp++;
      if (obs_q.size() != 1 || obs_q[0].d !== first) begin
         n_bad++;
         $display("FAIL rst_quiet got %0d strobes want 1 (%h)",
                  obs_q.size(), first);
      end
      obs_q.delete();
      b = rnd_nocr();
      in_data = b; in_strobe = 1'b1;
      @(negedge mclk);
      in_strobe = 1'b0;
      wait_obs(1, 200, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++; $display("FAIL rst_after got none want %h", b);
      end else begin
         o = obs_q.pop_front();
         n_cmp++;
         if (o.d !== b) begin
            n_bad++; $display("FAIL rst_after_data got %h want %h", o.d, b);
         end
      end
      repeat (20) @(negedge mclk);
   endtask

   initial begin
      @(negedge mclk);
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_crlf();
      test_timeout();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1);
   end

endmodule
